// File: rtl/gaussian_frame_ctrl_pkg.sv
// Shared definitions for the gaussian frame controller:
// register map, FSM state encoding and STATUS/CTRL bit positions.
package gaussian_frame_ctrl_pkg;

  localparam logic [19:0] ADDR_CTRL    = 20'h00;
  localparam logic [19:0] ADDR_WIDTH   = 20'h04;
  localparam logic [19:0] ADDR_HEIGHT  = 20'h08;
  localparam logic [19:0] ADDR_STATUS  = 20'h0C;
  localparam logic [19:0] ADDR_OUT_CNT = 20'h10;

  localparam int CTRL_START = 0;
  localparam int CTRL_FSEL  = 1;
  localparam int CTRL_ABORT = 2;

  localparam int STAT_DONE = 3;
  localparam int STAT_ERR  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/gaussian_line_gate.sv
// One host->filter line: combinational valid/ack pass-through gated by
// run and a per-line word counter that closes the line at TOTAL words.
// Ports: clk/rst, run, clr (new frame), hold (abort: freeze counter),
//   total, in_* (host side), out_* (filter side), done.
module gaussian_line_gate
  import gaussian_frame_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clr,
  input  logic             hold,
  input  logic [CNT_W-1:0] total,
  input  logic             in_valid,
  input  logic [63:0]      in_data,
  output logic             in_ack,
  output logic             out_valid,
  output logic [63:0]      out_data,
  input  logic             out_ack,
  output logic             done
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             done_q;
  logic             open_q;
  logic             fire;

  assign open_q    = run & ~done_q;
  assign out_valid = in_valid & open_q;
  assign in_ack    = out_ack & open_q;
  assign out_data  = in_data;
  assign fire      = out_valid & out_ack;
  assign cnt_inc   = cnt + CNT_W'(1);
  assign done      = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      done_q <= 1'b0;
    end else if (clr) begin
      cnt    <= '0;
      done_q <= 1'b0;
    end else if (fire && !hold) begin
      cnt <= cnt_inc;
      if (cnt_inc == total) done_q <= 1'b1;
    end
  end

endmodule

// File: rtl/gaussian_frame_ctrl.sv
// Frame controller for a 3-line gaussian filter: register file, frame FSM,
// three gated host->filter line streams and a gated filter->host result path.
// Ports: i_user_* / o_user_* register bus, i/o_pcie_str{1..3}_* host lines,
//   o/i_line{1..3}_* filter lines, *_flt_* and *_pcie_str1_* result path,
//   o_filter_sel, o_intr_req / i_intr_ack.
module gaussian_frame_ctrl
  import gaussian_frame_ctrl_pkg::*;
#(
  parameter int DIM_W = 16,
  parameter int CNT_W = 32
) (
  input  logic        i_user_clk,
  input  logic        i_rst,
  input  logic [31:0] i_user_data,
  input  logic [19:0] i_user_addr,
  input  logic        i_user_wr_req,
  input  logic        i_user_rd_req,
  output logic [31:0] o_user_data,
  output logic        o_user_rd_ack,
  input  logic        i_pcie_str1_data_valid,
  input  logic [63:0] i_pcie_str1_data,
  output logic        o_pcie_str1_ack,
  input  logic        i_pcie_str2_data_valid,
  input  logic [63:0] i_pcie_str2_data,
  output logic        o_pcie_str2_ack,
  input  logic        i_pcie_str3_data_valid,
  input  logic [63:0] i_pcie_str3_data,
  output logic        o_pcie_str3_ack,
  output logic        o_line1_data_valid,
  output logic [63:0] o_line1_data,
  input  logic        i_line1_data_ack,
  output logic        o_line2_data_valid,
  output logic [63:0] o_line2_data,
  input  logic        i_line2_data_ack,
  output logic        o_line3_data_valid,
  output logic [63:0] o_line3_data,
  input  logic        i_line3_data_ack,
  input  logic        i_flt_data_valid,
  input  logic [63:0] i_flt_data,
  output logic        o_flt_data_ack,
  output logic        o_pcie_str1_data_valid,
  output logic [63:0] o_pcie_str1_data,
  input  logic        i_pcie_str1_ack,
  output logic        o_filter_sel,
  output logic        o_intr_req,
  input  logic        i_intr_ack
);

  state_t           state;
  state_t           state_nx;
  logic [DIM_W-1:0] width_q;
  logic [DIM_W-1:0] height_q;
  logic             fsel_q;
  logic             err_q;
  logic             done_q;
  logic             intr_q;
  logic             rack_q;
  logic [31:0]      rdata_q;
  logic [31:0]      rd_mux;
  logic [31:0]      status;
  logic [CNT_W-1:0] total_q;
  logic [CNT_W-1:0] total_nx;
  logic [CNT_W-1:0] out_cnt;
  logic             wr_ctrl;
  logic             wr_idle;
  logic             start_cmd;
  logic             abort_cmd;
  logic             start_ok;
  logic             start_bad;
  logic             dims_ok;
  logic             run;
  logic             res_act;
  logic             res_fire;
  logic [2:0]       ln_done;
  logic             unused_data;

  assign unused_data = ^i_user_data;

  assign wr_ctrl   = i_user_wr_req && (i_user_addr == ADDR_CTRL);
  assign wr_idle   = i_user_wr_req && (state == ST_IDLE);
  assign start_cmd = wr_ctrl & i_user_data[CTRL_START];
  assign abort_cmd = wr_ctrl & i_user_data[CTRL_ABORT];
  assign dims_ok   = (width_q != '0) && (height_q >= DIM_W'(3));
  assign total_nx  = CNT_W'(width_q) * CNT_W'(height_q - DIM_W'(2));
  assign run       = (state == ST_RUN);

  // Result path stays open in RUN and DRAIN until the frame's last word.
  assign res_act = ((state == ST_RUN) || (state == ST_DRAIN))
                   && (out_cnt < total_q);
  assign o_pcie_str1_data_valid = i_flt_data_valid & res_act;
  assign o_flt_data_ack         = i_pcie_str1_ack & res_act;
  assign o_pcie_str1_data       = i_flt_data;
  assign res_fire = o_pcie_str1_data_valid & i_pcie_str1_ack;

  assign o_filter_sel  = fsel_q;
  assign o_intr_req    = intr_q;
  assign o_user_rd_ack = rack_q;
  assign o_user_data   = rdata_q;

  always_comb begin
    state_nx  = state;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    if (abort_cmd) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_cmd) begin
            if (dims_ok) begin
              state_nx = ST_RUN;
              start_ok = 1'b1;
            end else begin
              start_bad = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (out_cnt == total_q) state_nx = ST_DONE;
          else if (&ln_done)      state_nx = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (out_cnt == total_q) state_nx = ST_DONE;
        end
        ST_DONE: begin
          if (i_intr_ack) state_nx = ST_IDLE;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_user_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Frame geometry and mode are frozen once a frame is in flight.
  always_ff @(posedge i_user_clk or posedge i_rst) begin
    if (i_rst) begin
      width_q  <= '0;
      height_q <= '0;
      fsel_q   <= 1'b0;
    end else if (wr_idle) begin
      if (i_user_addr == ADDR_WIDTH)
        width_q <= DIM_W'(i_user_data);
      if (i_user_addr == ADDR_HEIGHT)
        height_q <= DIM_W'(i_user_data);
      if (i_user_addr == ADDR_CTRL)
        fsel_q <= i_user_data[CTRL_FSEL];
    end
  end

  always_ff @(posedge i_user_clk or posedge i_rst) begin
    if (i_rst) begin
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      total_q <= '0;
      out_cnt <= '0;
      intr_q  <= 1'b0;
    end else begin
      intr_q <= (state_nx == ST_DONE);
      if (start_ok) begin
        err_q   <= 1'b0;
        done_q  <= 1'b0;
        total_q <= total_nx;
        out_cnt <= '0;
      end else begin
        if (start_bad) begin
          err_q  <= 1'b1;
          done_q <= 1'b0;
        end
        if (state == ST_DONE && i_intr_ack && !abort_cmd)
          done_q <= 1'b1;
        if (res_fire && !abort_cmd)
          out_cnt <= out_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    status = '0;
    status[STAT_ERR]  = err_q;
    status[STAT_DONE] = done_q;
    status[1:0]       = state;
  end

  always_comb begin
    case (i_user_addr)
      ADDR_CTRL:    rd_mux = {30'd0, fsel_q, 1'b0};
      ADDR_WIDTH:   rd_mux = 32'(width_q);
      ADDR_HEIGHT:  rd_mux = 32'(height_q);
      ADDR_STATUS:  rd_mux = status;
      ADDR_OUT_CNT: rd_mux = 32'(out_cnt);
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge i_user_clk or posedge i_rst) begin
    if (i_rst) begin
      rack_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      rack_q <= i_user_rd_req;
      if (i_user_rd_req) rdata_q <= rd_mux;
    end
  end

  gaussian_line_gate #(.CNT_W(CNT_W)) u_line1 (
    .clk       (i_user_clk),
    .rst       (i_rst),
    .run       (run),
    .clr       (start_ok),
    .hold      (abort_cmd),
    .total     (total_q),
    .in_valid  (i_pcie_str1_data_valid),
    .in_data   (i_pcie_str1_data),
    .in_ack    (o_pcie_str1_ack),
    .out_valid (o_line1_data_valid),
    .out_data  (o_line1_data),
    .out_ack   (i_line1_data_ack),
    .done      (ln_done[0])
  );

  gaussian_line_gate #(.CNT_W(CNT_W)) u_line2 (
    .clk       (i_user_clk),
    .rst       (i_rst),
    .run       (run),
    .clr       (start_ok),
    .hold      (abort_cmd),
    .total     (total_q),
    .in_valid  (i_pcie_str2_data_valid),
    .in_data   (i_pcie_str2_data),
    .in_ack    (o_pcie_str2_ack),
    .out_valid (o_line2_data_valid),
    .out_data  (o_line2_data),
    .out_ack   (i_line2_data_ack),
    .done      (ln_done[1])
  );

  gaussian_line_gate #(.CNT_W(CNT_W)) u_line3 (
    .clk       (i_user_clk),
    .rst       (i_rst),
    .run       (run),
    .clr       (start_ok),
    .hold      (abort_cmd),
    .total     (total_q),
    .in_valid  (i_pcie_str3_data_valid),
    .in_data   (i_pcie_str3_data),
    .in_ack    (o_pcie_str3_ack),
    .out_valid (o_line3_data_valid),
    .out_data  (o_line3_data),
    .out_ack   (i_line3_data_ack),
    .done      (ln_done[2])
  );

endmodule

// File: tb/tb_gaussian_frame_ctrl.sv
// Scoreboard bench for gaussian_frame_ctrl: stream index 0 is the
// filter->host result path, indices 1..3 are the host->filter lines.
module tb_gaussian_frame_ctrl;
  import gaussian_frame_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ud;
  logic [19:0] ua;
  logic        wr;
  logic        rd;
  logic [31:0] uq;
  logic        rack;
  logic        fsel;
  logic        intr;
  logic        iack;

  logic        sv [0:3];
  logic [63:0] sd [0:3];
  logic        la [0:3];
  logic        ov [0:3];
  logic [63:0] od [0:3];
  logic        oa [0:3];

  logic [63:0] q [0:3][$];
  int          acc  [0:3];
  int          widx [0:3];
  bit          adv  [0:3];
  bit          bp;
  int          nchk;
  int          nerr;
  logic [31:0] rv;

  always #5 clk = ~clk;

  gaussian_frame_ctrl dut (
    .i_user_clk             (clk),
    .i_rst                  (rst),
    .i_user_data            (ud),
    .i_user_addr            (ua),
    .i_user_wr_req          (wr),
    .i_user_rd_req          (rd),
    .o_user_data            (uq),
    .o_user_rd_ack          (rack),
    .i_pcie_str1_data_valid (sv[1]),
    .i_pcie_str1_data       (sd[1]),
    .o_pcie_str1_ack        (oa[1]),
    .i_pcie_str2_data_valid (sv[2]),
    .i_pcie_str2_data       (sd[2]),
    .o_pcie_str2_ack        (oa[2]),
    .i_pcie_str3_data_valid (sv[3]),
    .i_pcie_str3_data       (sd[3]),
    .o_pcie_str3_ack        (oa[3]),
    .o_line1_data_valid     (ov[1]),
    .o_line1_data           (od[1]),
    .i_line1_data_ack       (la[1]),
    .o_line2_data_valid     (ov[2]),
    .o_line2_data           (od[2]),
    .i_line2_data_ack       (la[2]),
    .o_line3_data_valid     (ov[3]),
    .o_line3_data           (od[3]),
    .i_line3_data_ack       (la[3]),
    .i_flt_data_valid       (sv[0]),
    .i_flt_data             (sd[0]),
    .o_flt_data_ack         (oa[0]),
    .o_pcie_str1_data_valid (ov[0]),
    .o_pcie_str1_data       (od[0]),
    .i_pcie_str1_ack        (la[0]),
    .o_filter_sel           (fsel),
    .o_intr_req             (intr),
    .i_intr_ack             (iack)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic present(input int k);
    sd[k] = {8'(k), 24'($urandom), 32'(widx[k])};
    widx[k]++;
    q[k].push_back(sd[k]);
  endtask

  task automatic reset_streams();
    for (int k = 0; k < 4; k++) begin
      q[k].delete();
      acc[k]  = 0;
      widx[k] = 0;
      sv[k]   = 1'b1;
      la[k]   = 1'b1;
      present(k);
    end
  endtask

  // One clock: check handshakes at negedge, advance sources after posedge.
  task automatic step();
    logic sx;
    logic dx;
    logic [63:0] e;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      sx = sv[k] & oa[k];
      dx = ov[k] & la[k];
      adv[k] = sx;
      if (sx | dx)
        chk($sformatf("hs%0d", k), 64'(dx), 64'(sx));
      if (dx) begin
        e = (q[k].size() > 0) ? q[k].pop_front() : 64'hx;
        chk($sformatf("data%0d", k), od[k], e);
        acc[k]++;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++)
      if (adv[k]) present(k);
    if (bp) begin
      la[2] = 1'($urandom_range(0, 1));
      la[0] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wr_reg(input logic [19:0] a, input logic [31:0] d);
    ua = a;
    ud = d;
    wr = 1'b1;
    step();
    wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [19:0] a, output logic [31:0] d);
    ua = a;
    rd = 1'b1;
    step();
    rd = 1'b0;
    chk("rd_ack", 64'(rack), 64'd1);
    d = uq;
  endtask

  task automatic wait_intr(input int lim, input string tag);
    for (int i = 0; i < lim && !intr; i++) step();
    chk(tag, 64'(intr), 64'd1);
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    bp   = 1'b0;
    rst  = 1'b1;
    wr   = 1'b0;
    rd   = 1'b0;
    iack = 1'b0;
    ua   = '0;
    ud   = '0;
    for (int k = 0; k < 4; k++) begin
      sv[k]   = 1'b0;
      sd[k]   = '0;
      la[k]   = 1'b0;
      widx[k] = 0;
    end
    #12;
    chk("rst rd_ack", 64'(rack), 64'd0);
    chk("rst intr", 64'(intr), 64'd0);
    chk("rst fsel", 64'(fsel), 64'd0);
    chk("rst udata", 64'(uq), 64'd0);
    #10 rst = 1'b0;
    @(posedge clk);
    #1;
    rd_reg(ADDR_WIDTH, rv);
    chk("rst width", 64'(rv), 64'd0);
    rd_reg(ADDR_STATUS, rv);
    chk("rst status", 64'(rv), 64'd0);

    // Full-rate frame: 4 words x (5-2) rows = 12 words per stream.
    reset_streams();
    wr_reg(ADDR_WIDTH, 32'd4);
    wr_reg(ADDR_HEIGHT, 32'd5);
    chk("idle gate", 64'(ov[1] | oa[1] | ov[0]), 64'd0);
    wr_reg(ADDR_CTRL, 32'h1);
    wait_intr(100, "t1 intr");
    for (int k = 0; k < 4; k++)
      chk($sformatf("t1 cnt%0d", k), 64'(acc[k]), 64'd12);
    rd_reg(ADDR_OUT_CNT, rv);
    chk("t1 out_cnt", 64'(rv), 64'd12);
    step();
    step();
    chk("t1 intr hold", 64'(intr), 64'd1);
    rd_reg(ADDR_STATUS, rv);
    chk("t1 st done", 64'(rv), 64'h3);
    iack = 1'b1;
    step();
    iack = 1'b0;
    chk("t1 intr drop", 64'(intr), 64'd0);
    rd_reg(ADDR_STATUS, rv);
    chk("t1 status", 64'(rv), 64'h8);

    // Too few rows: error, no traffic.
    reset_streams();
    wr_reg(ADDR_HEIGHT, 32'd2);
    wr_reg(ADDR_CTRL, 32'h1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2 novalid", 64'(ov[0] | ov[1] | ov[2] | ov[3]), 64'd0);
    end
    rd_reg(ADDR_STATUS, rv);
    chk("t2 status", 64'(rv), 64'h10);

    // Random backpressure, filter_sel set, WIDTH write ignored in RUN.
    reset_streams();
    wr_reg(ADDR_HEIGHT, 32'd5);
    wr_reg(ADDR_CTRL, 32'h3);
    chk("t3 fsel", 64'(fsel), 64'd1);
    bp = 1'b1;
    wr_reg(ADDR_WIDTH, 32'd9);
    rd_reg(ADDR_WIDTH, rv);
    chk("t3 width ro", 64'(rv), 64'd4);
    wait_intr(400, "t3 intr");
    bp = 1'b0;
    for (int k = 0; k < 4; k++)
      chk($sformatf("t3 cnt%0d", k), 64'(acc[k]), 64'd12);
    la[2] = 1'b1;
    la[0] = 1'b1;
    #1;
    chk("t3 13th ack", 64'(oa[2]), 64'd0);
    chk("t3 13th res", 64'(ov[0]), 64'd0);
    iack = 1'b1;
    step();
    iack = 1'b0;
    rd_reg(ADDR_STATUS, rv);
    chk("t3 status", 64'(rv), 64'h8);

    // Abort on the same edge as the final result word.
    reset_streams();
    la[0] = 1'b0;
    wr_reg(ADDR_WIDTH, 32'd1);
    wr_reg(ADDR_HEIGHT, 32'd3);
    wr_reg(ADDR_CTRL, 32'h1);
    repeat (4) step();
    la[0] = 1'b1;
    wr_reg(ADDR_CTRL, 32'h4);
    chk("t4 res cnt", 64'(acc[0]), 64'd1);
    chk("t4 gated", 64'(ov[0]), 64'd0);
    repeat (3) step();
    chk("t4 no intr", 64'(intr), 64'd0);
    rd_reg(ADDR_STATUS, rv);
    chk("t4 status", 64'(rv), 64'h0);

    // Asynchronous reset in the middle of a frame.
    reset_streams();
    wr_reg(ADDR_WIDTH, 32'd4);
    wr_reg(ADDR_HEIGHT, 32'd5);
    wr_reg(ADDR_CTRL, 32'h3);
    repeat (3) step();
    chk("t5 running", 64'(ov[1]), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5 lv", 64'(ov[1] | ov[2] | ov[3]), 64'd0);
    chk("t5 la", 64'(oa[1] | oa[2] | oa[3]), 64'd0);
    chk("t5 res", 64'(ov[0] | oa[0]), 64'd0);
    chk("t5 fsel", 64'(fsel), 64'd0);
    #10 rst = 1'b0;
    @(posedge clk);
    #1;
    reset_streams();
    repeat (3) step();
    chk("t5 no intr", 64'(intr), 64'd0);
    chk("t5 idle", 64'(ov[1]), 64'd0);
    rd_reg(ADDR_STATUS, rv);
    chk("t5 status", 64'(rv), 64'h0);
    rd_reg(ADDR_OUT_CNT, rv);
    chk("t5 out_cnt", 64'(rv), 64'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/gaussian_frame_ctrl.md
GAUSSIAN_FRAME_CTRL -- requirements
Module: gaussian_frame_ctrl

Interface
REQ-001 SHALL have parameter DIM_W, default 16, width of the image width/height registers.
REQ-002 SHALL have parameter CNT_W, default 32, width of the word counters.
REQ-003 SHALL have port i_user_clk, input, 1, the single clock.
REQ-004 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have register-interface ports i_user_data in 32, i_user_addr in 20, i_user_wr_req in 1, i_user_rd_req in 1, o_user_data out 32, o_user_rd_ack out 1.
REQ-006 SHALL have host-side line ports, for n = 1..3: i_pcie_strn_data_valid in 1, i_pcie_strn_data in 64, o_pcie_strn_ack out 1.
REQ-007 SHALL have filter-side line ports, for n = 1..3: o_linen_data_valid out 1, o_linen_data out 64, i_linen_data_ack in 1.
REQ-008 SHALL have filter-result ports i_flt_data_valid in 1, i_flt_data in 64, o_flt_data_ack out 1.
REQ-009 SHALL have host-result ports o_pcie_str1_data_valid out 1, o_pcie_str1_data out 64, i_pcie_str1_ack in 1.
REQ-010 SHALL have ports o_filter_sel out 1 (filter mode to datapath), o_intr_req out 1, i_intr_ack in 1.

Function
REQ-011 Registers SHALL be: 0x00 CTRL (bit0 start, self-clearing; bit1 filter_sel; bit2 abort, self-clearing); 0x04 WIDTH in 64-bit words; 0x08 HEIGHT in rows; 0x0C STATUS read-only {err bit4, done bit3, state bits1:0}; 0x10 OUT_CNT read-only.
REQ-012 Writes SHALL take effect on the cycle after i_user_wr_req; WIDTH, HEIGHT and filter_sel writes SHALL be ignored while state is not IDLE.
REQ-013 o_user_rd_ack SHALL be i_user_rd_req delayed one cycle; o_user_data SHALL be registered, valid with rd_ack; unmapped addresses SHALL read 0.
REQ-014 FSM states SHALL be IDLE(0), RUN(1), DRAIN(2), DONE(3).
REQ-015 IDLE->RUN SHALL occur on start when WIDTH>=1 and HEIGHT>=3, loading TOTAL = WIDTH*(HEIGHT-2) (CNT_W bits) and clearing all counters and err.
REQ-016 A start with WIDTH=0 or HEIGHT<3 SHALL set err and keep the FSM in IDLE.
REQ-017 A start outside IDLE SHALL be ignored.
REQ-018 In RUN, line n SHALL pass through combinationally: o_linen_data_valid = i_pcie_strn_data_valid & ~lnn_done, o_pcie_strn_ack = i_linen_data_ack & ~lnn_done, o_linen_data = i_pcie_strn_data.
REQ-019 Line n's counter SHALL increment on valid&ack; lnn_done SHALL set when the counter reaches TOTAL.
REQ-020 Outside RUN, all line valids and acks SHALL be 0.
REQ-021 RUN->DRAIN SHALL occur the cycle after all three lnn_done are set.
REQ-022 In RUN and DRAIN, the result path SHALL pass through while OUT_CNT<TOTAL; OUT_CNT SHALL increment on valid&ack.
REQ-023 Once OUT_CNT=TOTAL, or in IDLE/DONE, o_pcie_str1_data_valid and o_flt_data_ack SHALL be 0.
REQ-024 When OUT_CNT reaches TOTAL, the FSM SHALL enter DONE on the next cycle, from RUN or DRAIN alike.
REQ-025 In DONE, o_intr_req SHALL be registered high until i_intr_ack is sampled high, then DONE->IDLE with done status set; done SHALL clear on the next start.
REQ-026 i_intr_ack outside DONE SHALL be ignored.
REQ-027 Abort in any state SHALL force IDLE next cycle, drop o_intr_req and freeze counters; abort SHALL have priority over simultaneous start, intr_ack or count completion.
REQ-028 o_filter_sel SHALL equal the filter_sel register bit.

Reset
REQ-029 i_rst SHALL asynchronously force state IDLE, all registers and counters to 0, and o_user_rd_ack, o_intr_req, o_filter_sel and o_user_data to 0.
REQ-030 Every gated valid/ack output SHALL be 0 during reset.
REQ-031 Reset mid-frame SHALL discard progress, with no interrupt issued.

Structure
REQ-032 A shared package SHALL hold the register address constants, the state encoding and the STATUS bit positions.
REQ-033 One sub-module, gaussian_line_gate, SHALL be instantiated three times, containing the per-line counter, done flag and valid/ack gating.

Verification
REQ-034 WIDTH=4, HEIGHT=5, start, all streams always valid/ack -> each line passes 12 words, OUT_CNT=12, DONE entered, intr held until ack, STATUS done=1.
REQ-035 HEIGHT=2, start -> err=1, state IDLE, no valid ever asserted.
REQ-036 Random backpressure on i_line2_data_ack and i_pcie_str1_ack -> no word lost or duplicated, counts exact, a 13th word offered is not acked.
REQ-037 Abort in the same cycle OUT_CNT reaches TOTAL -> IDLE, no intr.
REQ-038 Write WIDTH during RUN -> readback unchanged.
REQ-039 i_rst asserted mid-RUN asynchronously -> all outputs 0 immediately, IDLE after release.
